// File: rtl/mini16_pe_io_pkg.sv
// Shared definitions for the mini16 PE I/O bridge: channel-index width helper,
// bank-decode defaults and status register indices.
package mini16_pe_io_pkg;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    localparam int BANK_BC_DEFAULT       = 63;
    localparam int BANK_GRP_BASE_DEFAULT = 48;

    // Status indices above the per-channel counts are offsets from NUM_CH.
    localparam int STAT_SEL_W   = 4;
    localparam int STAT_OVF_OFS = 0;
    localparam int STAT_ID_OFS  = 1;

endpackage

// File: rtl/mini16_pe_io_if.sv
// Bus bundle between a master/CPU side and the mini16 PE I/O bridge.
interface mini16_pe_io_if
    import mini16_pe_io_pkg::*;
#(
    parameter int WIDTH_D   = 16,
    parameter int DEPTH_V_F = 16,
    parameter int NUM_CH    = 2,
    parameter int DEPTH_V_M = 17
);
    localparam int CW = ch_width(NUM_CH);
    localparam int IW = WIDTH_D + DEPTH_V_F;

    logic                  cpu_s2m_we;
    logic [CW-1:0]         cpu_s2m_ch;
    logic [IW-1:0]         cpu_s2m_data;
    logic [NUM_CH-1:0]     cpu_s2m_full;
    logic                  fifo_req_r;
    logic                  fifo_valid;
    logic [IW-1:0]         fifo_r_data;
    logic [CW-1:0]         fifo_r_ch;
    logic [DEPTH_V_M-1:0]  addr_i;
    logic [WIDTH_D-1:0]    data_i;
    logic                  we_i;
    logic                  m2s_we;
    logic                  imem_we;
    logic [DEPTH_V_M-1:0]  w_addr;
    logic [WIDTH_D-1:0]    w_data;
    logic                  status_re;
    logic [STAT_SEL_W-1:0] status_sel;
    logic [WIDTH_D-1:0]    status_data;

    modport master (
        output cpu_s2m_we, cpu_s2m_ch, cpu_s2m_data, fifo_req_r,
               addr_i, data_i, we_i, status_re, status_sel,
        input  cpu_s2m_full, fifo_valid, fifo_r_data, fifo_r_ch,
               m2s_we, imem_we, w_addr, w_data, status_data
    );

    modport slave (
        input  cpu_s2m_we, cpu_s2m_ch, cpu_s2m_data, fifo_req_r,
               addr_i, data_i, we_i, status_re, status_sel,
        output cpu_s2m_full, fifo_valid, fifo_r_data, fifo_r_ch,
               m2s_we, imem_we, w_addr, w_data, status_data
    );

endinterface

// File: rtl/mini16_pe_io_chfifo.sv
// Show-ahead synchronous FIFO for one s2m channel with occupancy count,
// registered full flag and a pulse for each push dropped while full.
module mini16_pe_io_chfifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH_LOG = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata,
    output logic [DEPTH_LOG:0] count,
    output logic               full,
    output logic               empty,
    output logic               ovf
);
    localparam int                 DEPTH   = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] CNT_MAX = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] CNT_ONE = (DEPTH_LOG + 1)'(1);
    localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG:0]   cnt, cnt_next;
    logic                 full_q, at_depth, push_ok, pop_ok;

    // Full is judged on the pre-cycle count, so a same-cycle pop never rescues a push.
    assign at_depth = (cnt == CNT_MAX);
    assign push_ok  = push & ~at_depth;
    assign pop_ok   = pop & (cnt != '0);

    // NOTE: always_comb assigns a default to every output first, so no latch can be inferred.
    always_comb begin
        cnt_next = cnt;
        if (push_ok && !pop_ok)
            cnt_next = cnt + CNT_ONE;
        else if (pop_ok && !push_ok)
            cnt_next = cnt - CNT_ONE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            cnt    <= cnt_next;
            full_q <= (cnt_next == CNT_MAX);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;
    assign full  = full_q;
    assign empty = (cnt == '0);
    assign ovf   = push & at_depth;

endmodule

// File: rtl/mini16_pe_io.sv
// mini16 PE I/O bridge: per-channel s2m FIFOs merged round-robin onto one
// master read port, master write bank decode, and CPU status readback.
module mini16_pe_io
    import mini16_pe_io_pkg::*;
#(
    parameter int WIDTH_D                = 16,
    parameter int DEPTH_V_F              = 16,
    parameter int NUM_CH                 = 2,
    parameter int DEPTH_FIFO             = 5,
    parameter int CORE_ID                = 0,
    parameter int GROUP_ID               = 0,
    parameter int DEPTH_V_M              = 17,
    parameter int DEPTH_B_M              = 11,
    parameter int MASTER_W_BANK_BC       = BANK_BC_DEFAULT,
    parameter int MASTER_W_BANK_GRP_BASE = BANK_GRP_BASE_DEFAULT,
    parameter int DEPTH_V_M2S            = 9,
    parameter int DEPTH_B_M2S            = 8
) (
    input logic          clk,
    input logic          reset,
    mini16_pe_io_if.slave bus
);
    localparam int CW = ch_width(NUM_CH);
    localparam int IW = WIDTH_D + DEPTH_V_F;
    localparam int BW = DEPTH_V_M - DEPTH_B_M;

    logic [NUM_CH-1:0]   push_vec, pop_vec, full_vec, empty_vec, ovf_pulse, ovf;
    logic [IW-1:0]       ch_rdata [NUM_CH];
    logic [DEPTH_FIFO:0] ch_count [NUM_CH];

    always_comb begin
        push_vec = '0;
        for (int c = 0; c < NUM_CH; c++)
            push_vec[c] = bus.cpu_s2m_we & (bus.cpu_s2m_ch == CW'(c));
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mini16_pe_io_chfifo #(.WIDTH(IW), .DEPTH_LOG(DEPTH_FIFO)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push_vec[g]),
            .pop   (pop_vec[g]),
            .wdata (bus.cpu_s2m_data),
            .rdata (ch_rdata[g]),
            .count (ch_count[g]),
            .full  (full_vec[g]),
            .empty (empty_vec[g]),
            .ovf   (ovf_pulse[g])
        );
    end

    // Round-robin output stage: reload whenever the register is empty or being consumed.
    logic          out_valid, load, found;
    logic [IW-1:0] out_data;
    logic [CW-1:0] out_ch, last_grant, grant;
    int            idx;

    assign load = ~out_valid | bus.fifo_req_r;

    always_comb begin
        found   = 1'b0;
        grant   = last_grant;
        idx     = 0;
        pop_vec = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!found && !empty_vec[idx]) begin
                found = 1'b1;
                grant = CW'(idx);
            end
        end
        if (load && found) pop_vec[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= CW'(NUM_CH - 1);
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data   <= ch_rdata[grant];
                out_ch     <= grant;
                last_grant <= grant;
            end
        end
    end

    // Master write decode: stage 1 captures the request, stage 2 registers the strobes.
    logic [DEPTH_V_M-1:0] addr_d1, w_addr_q;
    logic [WIDTH_D-1:0]   data_d1, w_data_q;
    logic                 we_d1, m2s_we_q, imem_we_q, hit, m2s_sel;
    logic [BW-1:0]        bank;

    assign bank    = addr_d1[DEPTH_V_M-1:DEPTH_B_M];
    assign hit     = we_d1 & ((bank == BW'(CORE_ID)) || (bank == BW'(MASTER_W_BANK_BC)) ||
                              (bank == BW'(MASTER_W_BANK_GRP_BASE + GROUP_ID)));
    assign m2s_sel = (addr_d1[DEPTH_V_M2S-1:DEPTH_B_M2S] == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_d1   <= '0;
            data_d1   <= '0;
            we_d1     <= 1'b0;
            m2s_we_q  <= 1'b0;
            imem_we_q <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
        end else begin
            addr_d1   <= bus.addr_i;
            data_d1   <= bus.data_i;
            we_d1     <= bus.we_i;
            m2s_we_q  <= hit & m2s_sel;
            imem_we_q <= hit & ~m2s_sel;
            w_addr_q  <= addr_d1;
            w_data_q  <= data_d1;
        end
    end

    // Status readback; a read of the overflow word clears it but keeps same-cycle overflows.
    logic [WIDTH_D-1:0] stat_next, stat_q;
    logic               ovf_clr;

    assign ovf_clr = bus.status_re & (bus.status_sel == STAT_SEL_W'(NUM_CH + STAT_OVF_OFS));

    always_comb begin
        stat_next = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (bus.status_sel == STAT_SEL_W'(c)) stat_next = WIDTH_D'(ch_count[c]);
        if (bus.status_sel == STAT_SEL_W'(NUM_CH + STAT_OVF_OFS))
            stat_next = WIDTH_D'(ovf);
        if (bus.status_sel == STAT_SEL_W'(NUM_CH + STAT_ID_OFS))
            stat_next = WIDTH_D'({BW'(GROUP_ID), BW'(CORE_ID)});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf    <= '0;
            stat_q <= '0;
        end else begin
            ovf <= (ovf & ~{NUM_CH{ovf_clr}}) | ovf_pulse;
            if (bus.status_re) stat_q <= stat_next;
        end
    end

    assign bus.cpu_s2m_full = full_vec;
    assign bus.fifo_valid   = out_valid;
    assign bus.fifo_r_data  = out_data;
    assign bus.fifo_r_ch    = out_ch;
    assign bus.m2s_we       = m2s_we_q;
    assign bus.imem_we      = imem_we_q;
    assign bus.w_addr       = w_addr_q;
    assign bus.w_data       = w_data_q;
    assign bus.status_data  = stat_q;

endmodule

// File: tb/tb_mini16_pe_io.sv
// Self-checking bench for mini16_pe_io: directed scenarios plus random traffic,
// compared each cycle against a queue-based behavioural model.
module tb_mini16_pe_io;
    localparam int NC    = 3;
    localparam int DF    = 2;
    localparam int DEPTH = 4;
    localparam int WD    = 16;
    localparam int VF    = 16;
    localparam int VM    = 17;
    localparam int CORE  = 5;
    localparam int GRP   = 2;
    localparam int IW    = WD + VF;
    localparam int CW    = 2;
    // Identity word: {GROUP_ID, CORE_ID} with each field as wide as the 6-bit bank field.
    localparam logic [WD-1:0] ID_WORD = WD'((GRP << 6) | CORE);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          s_we, s_req, s_wi, s_re;
    logic [CW-1:0] s_ch;
    logic [IW-1:0] s_sd;
    logic [VM-1:0] s_addr;
    logic [WD-1:0] s_data;
    logic [3:0]    s_sel;

    mini16_pe_io_if #(.WIDTH_D(WD), .DEPTH_V_F(VF), .NUM_CH(NC), .DEPTH_V_M(VM)) bus ();

    assign bus.cpu_s2m_we   = s_we;
    assign bus.cpu_s2m_ch   = s_ch;
    assign bus.cpu_s2m_data = s_sd;
    assign bus.fifo_req_r   = s_req;
    assign bus.addr_i       = s_addr;
    assign bus.data_i       = s_data;
    assign bus.we_i         = s_wi;
    assign bus.status_re    = s_re;
    assign bus.status_sel   = s_sel;

    mini16_pe_io #(
        .WIDTH_D(WD), .DEPTH_V_F(VF), .NUM_CH(NC), .DEPTH_FIFO(DF),
        .CORE_ID(CORE), .GROUP_ID(GRP), .DEPTH_V_M(VM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: per-channel queues, one output slot, two-deep write pipeline.
    logic [IW-1:0] mq [NC][$];
    bit            m_valid;
    logic [IW-1:0] m_data;
    int            m_ch, m_last;
    bit [NC-1:0]   m_ovf;
    logic [WD-1:0] m_status;
    bit            m_we1, m_m2s, m_imem;
    logic [VM-1:0] m_a1, m_waddr;
    logic [WD-1:0] m_d1, m_wdata;

    task automatic model_step();
        int          sz [NC];
        bit [NC-1:0] ovf_new;
        bit          found;
        int          c, bank;
        bit          hit;
        if (reset) begin
            for (int i = 0; i < NC; i++) mq[i].delete();
            m_valid = 0; m_data = '0; m_ch = 0; m_last = NC - 1;
            m_ovf = '0; m_status = '0;
            m_we1 = 0; m_a1 = '0; m_d1 = '0;
            m_m2s = 0; m_imem = 0; m_waddr = '0; m_wdata = '0;
            return;
        end
        for (int i = 0; i < NC; i++) sz[i] = mq[i].size();
        ovf_new = '0;
        if (!m_valid || s_req) begin
            found = 0;
            for (int k = 1; k <= NC; k++) begin
                c = (m_last + k) % NC;
                if (!found && sz[c] > 0) begin
                    found  = 1;
                    m_data = mq[c].pop_front();
                    m_ch   = c;
                    m_last = c;
                end
            end
            m_valid = found;
        end
        if (s_we && int'(s_ch) < NC) begin
            if (sz[s_ch] == DEPTH) ovf_new[s_ch] = 1'b1;
            else mq[s_ch].push_back(s_sd);
        end
        if (s_re) begin
            if (int'(s_sel) < NC)       m_status = WD'(sz[s_sel]);
            else if (int'(s_sel) == NC) m_status = WD'(m_ovf);
            else if (int'(s_sel) == NC + 1) m_status = ID_WORD;
            else m_status = '0;
        end
        if (s_re && int'(s_sel) == NC) m_ovf = ovf_new;
        else m_ovf = m_ovf | ovf_new;
        bank    = int'(m_a1 >> 11);
        hit     = m_we1 && (bank == CORE || bank == 63 || bank == 48 + GRP);
        m_m2s   = hit && !m_a1[8];
        m_imem  = hit && m_a1[8];
        m_waddr = m_a1;
        m_wdata = m_d1;
        m_we1   = s_wi;
        m_a1    = s_addr;
        m_d1    = s_data;
    endtask

    task automatic compare();
        bit [NC-1:0] exp_full;
        for (int i = 0; i < NC; i++) exp_full[i] = (mq[i].size() == DEPTH);
        check("fifo_valid", bus.fifo_valid, m_valid);
        if (m_valid) begin
            check("fifo_r_data", bus.fifo_r_data, m_data);
            check("fifo_r_ch", bus.fifo_r_ch, m_ch);
        end
        check("cpu_s2m_full", bus.cpu_s2m_full, exp_full);
        check("m2s_we", bus.m2s_we, m_m2s);
        check("imem_we", bus.imem_we, m_imem);
        if (m_m2s || m_imem) begin
            check("w_addr", bus.w_addr, m_waddr);
            check("w_data", bus.w_data, m_wdata);
        end
        check("status_data", bus.status_data, m_status);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic idle();
        s_we = 0; s_ch = '0; s_sd = '0; s_req = 0;
        s_wi = 0; s_addr = '0; s_data = '0; s_re = 0; s_sel = '0;
    endtask

    task automatic push(input int ch, input logic [IW-1:0] d);
        s_we = 1; s_ch = CW'(ch); s_sd = d;
        tick();
        s_we = 0;
    endtask

    function automatic logic [VM-1:0] mk_addr(input int bank, input bit m2s_hi);
        logic [VM-1:0] a;
        a = VM'($urandom);
        a[16:11] = 6'(bank);
        a[8] = m2s_hi;
        return a;
    endfunction

    int ord [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        check("rst_valid", bus.fifo_valid, 0);
        check("rst_rdata", bus.fifo_r_data, 0);
        check("rst_rch", bus.fifo_r_ch, 0);
        check("rst_full", bus.cpu_s2m_full, 0);
        check("rst_waddr", bus.w_addr, 0);
        check("rst_status", bus.status_data, 0);
        reset = 0;

        // Latency: push at cycle 0, valid at cycle 2, consumed at cycle 2.
        push(0, 32'h0010ABCD);
        check("lat_c1_valid", bus.fifo_valid, 0);
        tick();
        check("lat_c2_valid", bus.fifo_valid, 1);
        check("lat_c2_data", bus.fifo_r_data, 32'h0010ABCD);
        check("lat_c2_ch", bus.fifo_r_ch, 0);
        s_req = 1;
        tick();
        check("lat_c3_valid", bus.fifo_valid, 0);
        s_req = 0;

        // Round-robin order with all three channels loaded.
        for (int i = 0; i < 6; i++) push(i % 3, IW'(32'hC000_0000 + i));
        tick();
        s_req = 1;
        for (int i = 0; i < 6; i++) begin
            check("rr_valid", bus.fifo_valid, 1);
            check("rr_ch", bus.fifo_r_ch, ord[i]);
            tick();
        end
        check("rr_drained", bus.fifo_valid, 0);
        s_req = 0;

        // Overflow on ch1 and clear-on-read of the overflow word.
        for (int i = 0; i < 6; i++) push(1, IW'(32'h1100_0000 + i));
        check("ovf_full1", bus.cpu_s2m_full[1], 1);
        s_re = 1; s_sel = 4'(NC);
        tick();
        check("ovf_read1", bus.status_data, 16'h0002);
        tick();
        check("ovf_read2", bus.status_data, 16'h0000);
        s_sel = 4'd1;
        tick();
        check("ovf_count1", bus.status_data, 16'd4);
        s_sel = 4'(NC + 1);
        tick();
        check("id_word", bus.status_data, ID_WORD);
        s_re = 0; s_req = 1;
        repeat (6) tick();
        s_req = 0;

        // Master write decode, single then back-to-back.
        s_wi = 1; s_addr = mk_addr(CORE, 0); s_data = 16'h1234;
        tick();
        s_wi = 0;
        check("wr_t1_m2s", bus.m2s_we, 0);
        tick();
        check("wr_t2_m2s", bus.m2s_we, 1);
        check("wr_t2_data", bus.w_data, 16'h1234);
        tick();
        check("wr_t3_m2s", bus.m2s_we, 0);
        s_wi = 1; s_addr = mk_addr(63, 1); s_data = 16'h0063; tick();
        s_addr = mk_addr(48 + GRP, 0); s_data = 16'h0032; tick();
        check("wr_bc_imem", bus.imem_we, 1);
        s_addr = mk_addr(CORE + 1, 0); s_data = 16'h0006; tick();
        check("wr_grp_m2s", bus.m2s_we, 1);
        s_wi = 0; tick();
        check("wr_miss_m2s", bus.m2s_we, 0);
        check("wr_miss_imem", bus.imem_we, 0);
        tick();

        // Full ch2 with a same-cycle pop, push and overflow-word read.
        for (int i = 0; i < 5; i++) push(2, IW'(32'h2200_0000 + i));
        check("pp_full2", bus.cpu_s2m_full[2], 1);
        s_we = 1; s_ch = 2'd2; s_sd = 32'hDEAD_BEEF; s_req = 1; s_re = 1; s_sel = 4'(NC);
        tick();
        s_we = 0; s_req = 0;
        check("pp_read_pre", bus.status_data, 16'h0000);
        s_sel = 4'd2;
        tick();
        check("pp_count", bus.status_data, 16'(DEPTH - 1));
        s_sel = 4'(NC);
        tick();
        check("pp_ovf_kept", bus.status_data, 16'h0004);
        s_re = 0;

        // Reset while the output register holds an item and more are queued.
        for (int i = 0; i < 4; i++) push(i % 3, IW'(32'h3300_0000 + i));
        check("mid_valid", bus.fifo_valid, 1);
        reset = 1;
        tick();
        reset = 0;
        check("mid_rst_valid", bus.fifo_valid, 0);
        check("mid_rst_full", bus.cpu_s2m_full, 0);
        s_re = 1; s_sel = 4'd2;
        tick();
        check("mid_rst_count2", bus.status_data, 0);
        s_re = 0;

        // Random traffic in phases alternating fill-heavy and drain-heavy.
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 750; n++) begin
                s_we   = (p % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                s_req  = (p % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                s_ch   = CW'($urandom_range(0, 3));
                s_sd   = IW'($urandom);
                s_wi   = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 3))
                    0: s_addr = mk_addr(CORE, 1'($urandom));
                    1: s_addr = mk_addr(63, 1'($urandom));
                    2: s_addr = mk_addr(48 + GRP, 1'($urandom));
                    default: s_addr = mk_addr($urandom_range(0, 63), 1'($urandom));
                endcase
                s_data = WD'($urandom);
                s_re   = $urandom_range(0, 3) == 0;
                s_sel  = 4'($urandom_range(0, 7));
                reset  = $urandom_range(0, 299) == 0;
                tick();
            end
        end
        reset = 0;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
